// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter.
// Byte order within a word is most significant byte first.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_FRAME_BITS     = 10;
  localparam int UART_BYTES_PER_WORD = 3;
  localparam int UART_DATA_BITS      = 8;

  // Byte 0 is bits [23:16]; any index past the last byte returns the low byte.
  function automatic logic [7:0] word_byte(input logic [23:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = word[23:16];
      2'd1:    word_byte = word[15:8];
      default: word_byte = word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte serialiser: baud counter, bit index, shifter and START/DATA/STOP sequencing.
// A start request seen on the stop bit's last cycle chains straight into the next frame.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          terminal;

  assign terminal = (cnt_q == CNT_LAST);
  assign done     = (state_q == STOP) && terminal;
  assign tx       = tx_q;

  // tx_d always reflects the level of the state being entered, so the line is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          cnt_d   = '0;
          shift_d = byte_in;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (terminal) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (terminal) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (terminal) begin
          cnt_d = '0;
          if (start) begin
            state_d = START;
            shift_d = byte_in;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Sends a 24-bit FIFO word as three back-to-back 8N1 bytes, MSB byte first.
// Holds the word, selects bytes and reports progress to the FIFO control stage.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        tx_spi_sclk_wire,
  input  logic        rst,
  input  logic        word_valid,
  input  logic [23:0] word_data,
  output logic        word_ready,
  output logic        idle,
  output logic [1:0]  uart_counter,
  output logic        uart_tx,
  output logic        word_done
);

  localparam logic [1:0] LAST_BYTE = 2'(UART_BYTES_PER_WORD - 1);

  logic        idle_q, idle_d;
  logic [1:0]  counter_q, counter_d;
  logic [23:0] hold_q, hold_d;
  logic        start_q, start_d;
  logic        word_done_q, word_done_d;
  logic        accept;
  logic        byte_done;
  logic        byte_start;
  logic [1:0]  byte_sel;

  assign accept     = idle_q && word_valid;
  // The next byte is launched on the stop bit's final cycle so frames abut with no gap.
  assign byte_start = start_q || (byte_done && (counter_q != LAST_BYTE));
  assign byte_sel   = byte_done ? (counter_q + 2'd1) : counter_q;

  always_comb begin
    idle_d      = idle_q;
    counter_d   = counter_q;
    hold_d      = hold_q;
    start_d     = 1'b0;
    word_done_d = 1'b0;
    if (accept) begin
      hold_d    = word_data;
      idle_d    = 1'b0;
      counter_d = '0;
      start_d   = 1'b1;
    end else if (!idle_q && byte_done) begin
      if (counter_q != LAST_BYTE) begin
        counter_d = counter_q + 2'd1;
      end else begin
        counter_d   = '0;
        idle_d      = 1'b1;
        word_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tx_spi_sclk_wire or posedge rst) begin
    if (rst) begin
      idle_q      <= 1'b1;
      counter_q   <= '0;
      hold_q      <= '0;
      start_q     <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      counter_q   <= counter_d;
      hold_q      <= hold_d;
      start_q     <= start_d;
      word_done_q <= word_done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (tx_spi_sclk_wire),
    .rst    (rst),
    .start  (byte_start),
    .byte_in(word_byte(hold_q, byte_sel)),
    .done   (byte_done),
    .tx     (uart_tx)
  );

  assign word_ready   = idle_q;
  assign idle         = idle_q;
  assign uart_counter = counter_q;
  assign word_done    = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Checks uart_word_tx at CLKS_PER_BIT=4 and 2 against a per-cycle line model
// built from the 8N1 framing rules.
module tb_uart_word_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid4, valid2;
  logic [23:0] data4, data2;
  logic        ready4, idle4, tx4, done4;
  logic        ready2, idle2, tx2, done2;
  logic [1:0]  cnt4, cnt2;

  int vectors = 0;
  int miscompares = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(4)) dut4 (
    .tx_spi_sclk_wire(clk), .rst(rst), .word_valid(valid4), .word_data(data4),
    .word_ready(ready4), .idle(idle4), .uart_counter(cnt4), .uart_tx(tx4), .word_done(done4)
  );

  uart_word_tx #(.CLKS_PER_BIT(2)) dut2 (
    .tx_spi_sclk_wire(clk), .rst(rst), .word_valid(valid2), .word_data(data2),
    .word_ready(ready2), .idle(idle2), .uart_counter(cnt2), .uart_tx(tx2), .word_done(done2)
  );

  // Line level at frame slot 'slot' of a word: start 0, data LSB first, stop 1.
  function automatic logic exp_line(input logic [23:0] w, input int slot);
    int         b;
    int         pos;
    logic [7:0] by;
    b   = slot / UART_FRAME_BITS;
    pos = slot % UART_FRAME_BITS;
    by  = 8'(w >> (8 * (UART_BYTES_PER_WORD - 1 - b)));
    if (pos == 0) return 1'b0;
    if (pos == UART_FRAME_BITS - 1) return 1'b1;
    return by[pos-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic e_tx, input logic e_idle,
                           input logic [1:0] e_cnt, input logic e_done);
    chk({tag, ".uart_tx"},      24'(sel ? tx2 : tx4),       24'(e_tx));
    chk({tag, ".idle"},         24'(sel ? idle2 : idle4),   24'(e_idle));
    chk({tag, ".word_ready"},   24'(sel ? ready2 : ready4), 24'(e_idle));
    chk({tag, ".uart_counter"}, 24'(sel ? cnt2 : cnt4),     24'(e_cnt));
    chk({tag, ".word_done"},    24'(sel ? done2 : done4),   24'(e_done));
  endtask

  task automatic drive(input logic v, input logic [23:0] d);
    if (sel) begin
      valid2 = v;
      data2  = d;
    end else begin
      valid4 = v;
      data4  = d;
    end
  endtask

  // mode 0: drop valid after acceptance; 1: keep valid high; 2: disturb inputs during byte 1.
  task automatic send_word(input logic [23:0] w, input int mode, input int abort_k);
    int c;
    int frame;
    c     = sel ? 2 : 4;
    frame = UART_FRAME_BITS * UART_BYTES_PER_WORD * c;
    chk("pre_accept.idle", 24'(sel ? idle2 : idle4), 24'd1);
    drive(1'b1, w);
    tick();
    chk_state("accept", 1'b1, 1'b0, 2'd0, 1'b0);
    if (mode != 1) drive(1'b0, 24'($urandom));
    tick();
    for (int k = 0; k < frame; k++) begin
      if (k == abort_k) begin
        drive(1'b0, 24'd0);
        rst = 1'b1;
        #1;
        chk_state("reset_async", 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        chk_state("reset_held", 1'b1, 1'b1, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_state("reset_release", 1'b1, 1'b1, 2'd0, 1'b0);
        return;
      end
      chk_state("frame", exp_line(w, k / c), 1'b0, 2'(k / (UART_FRAME_BITS * c)), 1'b0);
      if (mode == 2) begin
        if (k >= 10 * c && k < 20 * c) drive(k[0], 24'($urandom));
        else drive(1'b0, 24'($urandom));
      end
      tick();
    end
    chk_state("word_done", 1'b1, 1'b1, 2'd0, 1'b1);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_state(tag, 1'b1, 1'b1, 2'd0, 1'b0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    valid4 = 1'b0;
    valid2 = 1'b0;
    data4  = '0;
    data2  = '0;
    tick();
    tick();
    sel = 1'b0;
    chk_state("reset4", 1'b1, 1'b1, 2'd0, 1'b0);
    sel = 1'b1;
    chk_state("reset2", 1'b1, 1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    sel = 1'b0;
    idle_cycles("idle50", 50);

    send_word(24'hA5C301, 0, -1);
    idle_cycles("after_a5c301", 2);

    send_word(24'h000001, 1, -1);
    send_word(24'hFFFFFF, 0, -1);
    idle_cycles("after_b2b", 2);

    send_word(24'h123456, 2, -1);
    idle_cycles("single_accept", 6);

    // Bit 3 of byte 1 at CLKS_PER_BIT=4: frame slot 14, mid-bit.
    send_word(24'hABCDEF, 0, 14 * 4 + 2);
    idle_cycles("post_reset", 3);
    send_word(24'h0F0F0F, 0, -1);
    idle_cycles("after_0f0f0f", 2);

    sel = 1'b1;
    send_word(24'h800001, 0, -1);
    idle_cycles("after_800001", 2);

    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      idle_cycles("rand_gap", $urandom_range(0, 4));
      send_word(24'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2, -1);
    end
    idle_cycles("final", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
